// File: rtl/cr_xp10_decomp_be_packer_pkg.sv
// Shared types for the XP10 decompressor back-end packer: LZ77 data-out bus
// layout, word type codes, packer FSM states and mask decode helpers.
package cr_xp10_decompPKG;

  // 74-bit LZ77 -> back-end data word: payload, word type, byte mask.
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  data_type;
    logic [7:0]  bytes_valid;
  } lz_be_dp_bus_t;

  localparam logic [1:0] DP_EOB     = 2'b00;
  localparam logic [1:0] DP_DATA    = 2'b01;
  localparam logic [1:0] DP_EOF     = 2'b10;
  localparam logic [1:0] DP_EOF_ERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_FLUSH = 2'b10
  } be_pack_state_e;

  // Byte count carried by a mask: highest set bit + 1, so a contiguous mask
  // gives its popcount and a holey mask is treated as filled below its top bit.
  function automatic logic [3:0] mask_nbytes(input logic [7:0] mask);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        n = 4'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Contiguous-LSB mask with n bytes set (n in 0..8).
  function automatic logic [7:0] nbytes_mask(input logic [4:0] n);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = (5'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_be_packer_nx_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. Writes to a full FIFO
// and reads from an empty FIFO are ignored. DEPTH must be a power of two.
module nx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 74
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] used
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]    used_q, used_d;
  logic             wr_acc, rd_acc;

  assign empty   = (used_q == {UW{1'b0}});
  assign full    = (used_q == UW'(DEPTH));
  assign used    = used_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_acc ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = rd_acc ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({wr_acc, rd_acc})
      2'b10:   used_d = used_q + UW'(1);
      2'b01:   used_d = used_q - UW'(1);
      default: used_d = used_q;
    endcase
  end

  // Storage array; contents need no reset since reads are gated by used_q.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      used_q   <= {UW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_be_packer.sv
// Back-end receiver of the LZ77 data-out bus: buffers incoming words in a
// skid FIFO, packs their valid bytes into dense 8-byte words and flushes the
// tail word at end-of-frame with EOF/error flags and the frame byte count.
module cr_xp10_decomp_be_packer
  import cr_xp10_decompPKG::*;
#(
  parameter int IN_DEPTH = 16,
  parameter int CNT_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lz_be_dp_valid,
  input  lz_be_dp_bus_t    lz_be_dp_bus,
  output logic             be_lz_dp_ready,
  output logic             be_out_valid,
  output logic [63:0]      be_out_data,
  output logic [7:0]       be_out_bytes_valid,
  output logic             be_out_eof,
  output logic             be_out_err,
  input  logic             be_out_ready,
  output logic [CNT_W-1:0] be_byte_count,
  output logic             be_overflow
);

  localparam int UW = $clog2(IN_DEPTH + 1);

  logic [73:0]     fifo_rd_data;
  logic            fifo_empty, fifo_full, fifo_pop;
  logic [UW-1:0]   fifo_used;
  lz_be_dp_bus_t   head;
  logic [3:0]      head_nb;
  logic [63:0]     head_keep;
  logic            head_eof, head_err, head_payload;

  be_pack_state_e  state_q, state_d;
  logic [127:0]    acc_q, acc_d, acc_shift;
  logic [4:0]      acc_cnt_q, acc_cnt_d, cnt_shift;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W:0]  frame_sum;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [63:0]     out_data_q, out_data_d;
  logic [7:0]      out_mask_q, out_mask_d;
  logic            out_eof_q, out_eof_d;
  logic            out_err_q, out_err_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic            ready_q, ready_d;
  logic            ovf_q, ovf_d;
  logic            out_free, emit, emit_last;

  nx_fifo #(.DEPTH(IN_DEPTH), .WIDTH(74)) u_in_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (lz_be_dp_valid),
    .wr_data (lz_be_dp_bus),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .used    (fifo_used)
  );

  assign head               = fifo_rd_data;
  assign be_lz_dp_ready     = ready_q;
  assign be_out_valid       = out_valid_q;
  assign be_out_data        = out_data_q;
  assign be_out_bytes_valid = out_mask_q;
  assign be_out_eof         = out_eof_q;
  assign be_out_err         = out_err_q;
  assign be_byte_count      = out_cnt_q;
  assign be_overflow        = ovf_q;

  // Decode the FIFO head word: byte count, payload keep-mask and type class.
  always_comb begin
    head_nb      = mask_nbytes(head.bytes_valid);
    head_eof     = (head.data_type == DP_EOF) || (head.data_type == DP_EOF_ERR);
    head_err     = (head.data_type == DP_EOF_ERR);
    head_payload = (head.data_type == DP_DATA) || (head.data_type == DP_EOB);
    head_keep    = 64'd0;
    for (int i = 0; i < 8; i++) begin
      head_keep[i*8 +: 8] = (4'(i) < head_nb) ? 8'hFF : 8'h00;
    end
  end

  // Packing FSM: decides pop/emit, updates accumulator, count and output word.
  // A full 8-byte word is only emitted once more bytes of the same frame are
  // known to follow, so the last data word of a frame can carry the EOF flag.
  always_comb begin
    fifo_pop    = 1'b0;
    emit        = 1'b0;
    emit_last   = 1'b0;
    state_d     = state_q;
    err_d       = err_q;
    out_free    = !out_valid_q || be_out_ready;
    out_valid_d = out_valid_q && !be_out_ready;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_eof_d   = out_eof_q;
    out_err_d   = out_err_q;
    out_cnt_d   = out_cnt_q;
    ready_d     = (fifo_used < UW'(IN_DEPTH - 3));
    ovf_d       = ovf_q || (lz_be_dp_valid && fifo_full);

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (acc_cnt_q > 5'd8) begin
          emit = out_free;
        end else if (out_free && !fifo_empty) begin
          fifo_pop = 1'b1;
          emit     = (acc_cnt_q == 5'd8) && !head_eof && (head_nb != 4'd0);
        end else begin
          emit = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_last = (acc_cnt_q <= 5'd8);
        end else begin
          emit = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q[63:0];
      acc_shift   = acc_q >> 64;
      if (emit_last) begin
        out_mask_d = nbytes_mask(acc_cnt_q);
        out_eof_d  = 1'b1;
        out_err_d  = err_q;
        out_cnt_d  = frame_cnt_q;
        cnt_shift  = 5'd0;
      end else begin
        out_mask_d = 8'hFF;
        out_eof_d  = 1'b0;
        out_err_d  = 1'b0;
        out_cnt_d  = {CNT_W{1'b0}};
        cnt_shift  = acc_cnt_q - 5'd8;
      end
    end else begin
      acc_shift = acc_q;
      cnt_shift = acc_cnt_q;
    end

    frame_sum = {1'b0, frame_cnt_q} + {{(CNT_W-3){1'b0}}, head_nb};
    if (fifo_pop) begin
      acc_d       = acc_shift | ({64'd0, head.data & head_keep} << {cnt_shift, 3'b000});
      acc_cnt_d   = cnt_shift + {1'b0, head_nb};
      frame_cnt_d = frame_sum[CNT_W] ? {CNT_W{1'b1}} : frame_sum[CNT_W-1:0];
      if (head_eof) begin
        state_d = ST_FLUSH;
        err_d   = head_err;
      end else if (head_payload && (head_nb != 4'd0)) begin
        state_d = ST_ACCUM;
      end else begin
        state_d = state_q;
      end
    end else if (emit_last) begin
      acc_d       = 128'd0;
      acc_cnt_d   = 5'd0;
      frame_cnt_d = {CNT_W{1'b0}};
      state_d     = ST_IDLE;
    end else begin
      acc_d       = acc_shift;
      acc_cnt_d   = cnt_shift;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State, accumulator, output word and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= 128'd0;
      acc_cnt_q   <= 5'd0;
      frame_cnt_q <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      out_mask_q  <= 8'h00;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_cnt_q   <= {CNT_W{1'b0}};
      ready_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      out_cnt_q   <= out_cnt_d;
      ready_q     <= ready_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cr_xp10_decomp_be_packer.sv
// Scoreboard bench for cr_xp10_decomp_be_packer: a byte-queue reference model
// predicts packed output words, a negedge monitor compares every transfer.
module tb_cr_xp10_decomp_be_packer;
  import cr_xp10_decompPKG::*;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lz_be_dp_valid;
  lz_be_dp_bus_t    lz_be_dp_bus;
  logic             be_lz_dp_ready;
  logic             be_out_valid;
  logic [63:0]      be_out_data;
  logic [7:0]       be_out_bytes_valid;
  logic             be_out_eof;
  logic             be_out_err;
  logic             be_out_ready;
  logic [CNT_W-1:0] be_byte_count;
  logic             be_overflow;

  always #5 clk = ~clk;

  cr_xp10_decomp_be_packer #(.IN_DEPTH(16), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lz_be_dp_valid     (lz_be_dp_valid),
    .lz_be_dp_bus       (lz_be_dp_bus),
    .be_lz_dp_ready     (be_lz_dp_ready),
    .be_out_valid       (be_out_valid),
    .be_out_data        (be_out_data),
    .be_out_bytes_valid (be_out_bytes_valid),
    .be_out_eof         (be_out_eof),
    .be_out_err         (be_out_err),
    .be_out_ready       (be_out_ready),
    .be_byte_count      (be_byte_count),
    .be_overflow        (be_overflow)
  );

  typedef struct {
    logic [63:0]      data;
    logic [7:0]       mask;
    logic             eof;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t         exp_q[$];
  byte unsigned mbuf[$];
  int           mtotal = 0;
  int           n_vec = 0;
  int           n_fail = 0;
  bit           mon_en = 1'b1;
  int           bp_mode = 0;
  logic         rdy_prev;
  bit           saw_low;

  // Upstream sees ready with one cycle of read latency.
  always @(posedge clk) rdy_prev <= be_lz_dp_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {63'd0, be_lz_dp_ready}, 64'd0);
    chk({tag, "_valid"}, {63'd0, be_out_valid}, 64'd0);
    chk({tag, "_data"}, be_out_data, 64'd0);
    chk({tag, "_mask"}, {56'd0, be_out_bytes_valid}, 64'd0);
    chk({tag, "_eof"}, {63'd0, be_out_eof}, 64'd0);
    chk({tag, "_err"}, {63'd0, be_out_err}, 64'd0);
    chk({tag, "_count"}, {40'd0, be_byte_count}, 64'd0);
    chk({tag, "_overflow"}, {63'd0, be_overflow}, 64'd0);
  endtask

  // Reference: take the first n bytes of the frame byte stream as one output word.
  task automatic model_emit(input int n, input bit eof, input bit err, input int cnt);
    exp_t e;
    e.data = 64'd0;
    for (int i = 0; i < n; i++) e.data[i*8 +: 8] = mbuf.pop_front();
    e.mask = 8'((1 << n) - 1);
    e.eof  = eof;
    e.err  = err;
    e.cnt  = CNT_W'(cnt);
    exp_q.push_back(e);
  endtask

  // Reference: a full word leaves only once further bytes of the frame exist;
  // EOF drains the rest, the last word holding 1..8 bytes (or 0 for an empty frame).
  task automatic model_add(input logic [1:0] t, input logic [7:0] m, input logic [63:0] d);
    int nb;
    nb = 0;
    for (int i = 0; i < 8; i++) if (m[i]) nb = i + 1;
    for (int i = 0; i < nb; i++) mbuf.push_back(d[i*8 +: 8]);
    mtotal += nb;
    while (mbuf.size() > 8) model_emit(8, 1'b0, 1'b0, 0);
    if (t[1]) begin
      model_emit(mbuf.size(), 1'b1, t[0], mtotal);
      mtotal = 0;
    end
  endtask

  task automatic send_word(input logic [1:0] t, input logic [7:0] m, input logic [63:0] d);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (rdy_prev) begin
        lz_be_dp_valid = 1'b1;
        lz_be_dp_bus   = '{data: d, data_type: t, bytes_valid: m};
        model_add(t, m, d);
        done = 1'b1;
      end else begin
        lz_be_dp_valid = 1'b0;
        k++;
        if (k > 2000) begin
          n_vec++;
          n_fail++;
          $display("FAIL send_timeout: ready stayed low %0d cycles, expected it to return", k);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1;
    lz_be_dp_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || be_out_valid) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [7:0] rand_mask();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 8'hFF;
    else if (r == 5) return 8'h00;
    else if (r == 6) return 8'($urandom);
    else return 8'((1 << $urandom_range(1, 8)) - 1);
  endfunction

  // Downstream ready: always on, random, or held off.
  initial begin
    be_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       be_out_ready = 1'b1;
        1:       be_out_ready = ($urandom_range(0, 3) != 0);
        default: be_out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: each transfer (valid && ready) pops one expected word.
  exp_t        mon_e;
  logic [63:0] mon_keep;
  always @(negedge clk) begin
    if (mon_en && rst_n && be_out_valid && be_out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got data=%h mask=%h eof=%b, expected no word",
                 be_out_data, be_out_bytes_valid, be_out_eof);
      end else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) mon_keep[i*8 +: 8] = {8{mon_e.mask[i]}};
        if (((be_out_data & mon_keep) !== mon_e.data) || (be_out_bytes_valid !== mon_e.mask) ||
            (be_out_eof !== mon_e.eof) ||
            (mon_e.eof && ((be_out_err !== mon_e.err) || (be_byte_count !== mon_e.cnt)))) begin
          n_fail++;
          $display("FAIL out_word: got data=%h mask=%h eof=%b err=%b cnt=%0d, expected data=%h mask=%h eof=%b err=%b cnt=%0d",
                   be_out_data & mon_keep, be_out_bytes_valid, be_out_eof, be_out_err, be_byte_count,
                   mon_e.data, mon_e.mask, mon_e.eof, mon_e.err, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    lz_be_dp_valid = 1'b0;
    lz_be_dp_bus   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Four full data words then an empty EOF.
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'(w * 8 + b);
      send_word(2'b01, 8'hFF, d);
    end
    send_word(2'b10, 8'h00, 64'd0);
    idle_in();
    wait_drain("drain_full_words");

    // Partial masks, EOF carrying one payload byte.
    for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'(8'h10 + b);
    send_word(2'b01, 8'h07, d);
    for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'(8'h20 + b);
    send_word(2'b01, 8'h1F, d);
    for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'(8'h30 + b);
    send_word(2'b00, 8'h0F, d);
    send_word(2'b10, 8'h01, 64'h0000_0000_0000_00AA);
    idle_in();
    wait_drain("drain_partial");

    // EOF-error on an empty frame.
    send_word(2'b11, 8'h00, {$urandom, $urandom});
    idle_in();
    wait_drain("drain_eof_err");

    // Random frames under random downstream backpressure.
    bp_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int w = $urandom_range(0, 6); w > 0; w--) begin
        send_word(($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01, rand_mask(), {$urandom, $urandom});
      end
      send_word($urandom_range(0, 1) ? 2'b11 : 2'b10, rand_mask(), {$urandom, $urandom});
    end
    idle_in();
    bp_mode = 0;
    wait_drain("drain_random");

    // Downstream held off 20 cycles while input streams continuously.
    saw_low = 1'b0;
    fork
      begin
        for (int w = 0; w < 30; w++) send_word(2'b01, 8'hFF, {$urandom, $urandom});
        send_word(2'b10, 8'h0F, {$urandom, $urandom});
        idle_in();
      end
      begin
        bp_mode = 2;
        repeat (20) begin
          @(negedge clk);
          if (!be_lz_dp_ready) saw_low = 1'b1;
        end
        bp_mode = 0;
      end
    join
    chk("hold_ready_dropped", {63'd0, saw_low}, 64'd1);
    chk("hold_no_overflow", {63'd0, be_overflow}, 64'd0);
    wait_drain("drain_hold");

    // Forced writes while the FIFO is full set the sticky overflow flag.
    mon_en  = 1'b0;
    bp_mode = 2;
    repeat (30) begin
      @(posedge clk);
      #1;
      lz_be_dp_valid = 1'b1;
      lz_be_dp_bus   = '{data: {$urandom, $urandom}, data_type: 2'b01, bytes_valid: 8'hFF};
    end
    idle_in();
    chk("overflow_set", {63'd0, be_overflow}, 64'd1);
    bp_mode = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("overflow_sticky", {63'd0, be_overflow}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("reset_after_ovf");
    exp_q.delete();
    mbuf.delete();
    mtotal = 0;
    rst_n = 1'b1;

    // Reset in the middle of a frame, then a fresh frame counts from zero.
    for (int w = 0; w < 3; w++) send_word(2'b01, 8'hFF, {$urandom, $urandom});
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("reset_mid_frame");
    exp_q.delete();
    mbuf.delete();
    mtotal = 0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    send_word(2'b01, 8'hFF, {$urandom, $urandom});
    send_word(2'b01, 8'hFF, {$urandom, $urandom});
    send_word(2'b10, 8'h03, {$urandom, $urandom});
    idle_in();
    wait_drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
